// File: rtl/sram_like_pkg.sv
// Shared types and width helpers for the SRAM-like responder and its request queue.
package sram_like_pkg;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 30;
    localparam logic [3:0]  WSTRB_ALL = 4'hF;

    // cnt sits in the low bits so the queue can decrement it without knowing the rest
    typedef struct packed {
        logic             wr;
        logic [IDX_W-1:0] idx;
        logic [31:0]      wdata;
        logic [3:0]       wstrb;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sram_like_slave_resp_fifo.sv
// In-order request queue; the head entry's wait counter can be decremented in place.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned W      = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned PTR_W = ptr_w(QDEPTH);
    localparam int unsigned CW    = cnt_w(QDEPTH);

    logic [W-1:0]     slots [QDEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [CW-1:0]    count;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CW'(QDEPTH));
    assign empty = (count == '0);
    assign head  = slots[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= bump(wptr);
            if (pop)  rptr <= bump(rptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // push never targets the head slot while it is being decremented
    always_ff @(posedge clk) begin
        if (push) slots[wptr] <= din;
        if (dec)  slots[rptr][CNT_W-1:0] <= slots[rptr][CNT_W-1:0] - CNT_W'(1);
    end

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like memory responder: queued address phases retire in order after WAIT cycles at the head.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT       = 0,
    parameter int unsigned QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           mem [WORDS];
    entry_t                in_e;
    entry_t                head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  dec;
    logic [DEPTH_LOG2-1:0] head_idx;
    logic                  unused_bits;

    assign in_e = '{wr: wr, idx: addr[31:2], wdata: wdata, wstrb: wstrb, cnt: CNT_W'(WAIT)};

    assign addr_ok  = !full && !rst;
    assign busy     = !empty;
    assign push     = req && addr_ok;
    assign pop      = !rst && !empty && (head.cnt == '0);
    assign dec      = !rst && !empty && (head.cnt != '0);
    assign head_idx = head.idx[DEPTH_LOG2-1:0];

    // byte-offset and aliased upper address bits are intentionally dropped
    assign unused_bits = ^{addr[1:0], head.idx[IDX_W-1:DEPTH_LOG2]};

    resp_fifo #(
        .QDEPTH(QDEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .dec  (dec),
        .din  (in_e),
        .full (full),
        .empty(empty),
        .head (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_ok <= 1'b0;
            rdata   <= '0;
        end else if (pop) begin
            data_ok <= 1'b1;
            rdata   <= head.wr ? 32'h0 : mem[head_idx];
        end else begin
            data_ok <= 1'b0;
        end
    end

    // writes commit only at retire, so a reset drops queued writes
    always_ff @(posedge clk) begin
        if (pop && head.wr) begin
            if (head.wstrb == WSTRB_ALL) begin
                mem[head_idx] <= head.wdata;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (head.wstrb[b]) mem[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench: three responders (WAIT 0/3/5) each checked every cycle against a retire-time model.
module tb_sram_like_slave;

    localparam int unsigned QD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic [2:0]  req_v;
    logic [2:0]  wr_v;
    logic [2:0]  addr_ok_v;
    logic [2:0]  busy_v;
    logic [3:0]  wstrb_a [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];

    int checks = 0;
    int errors = 0;
    bit ao_hist[$];

    typedef struct {
        bit          wr;
        int unsigned idx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ret;
    } pend_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned WT = (g == 0) ? 0 : ((g == 1) ? 3 : 5);

        logic        addr_ok;
        logic        data_ok;
        logic        busy;
        logic [31:0] rdata;

        pend_t       pq[$];
        logic [31:0] mm [int unsigned];
        int          e = 0;
        int          last_ret = -100;
        bit          started = 1'b0;
        bit          exp_dok = 1'b0;
        logic [31:0] exp_rd = 32'h0;
        logic [31:0] resp_q[$];
        int          resp_t[$];
        int          acc_t[$];

        sram_like_slave #(
            .DEPTH_LOG2(10),
            .WAIT      (WT),
            .QDEPTH    (QD)
        ) u_dut (
            .clk    (clk),
            .rst    (rst_v[g]),
            .req    (req_v[g]),
            .wr     (wr_v[g]),
            .wstrb  (wstrb_a[g]),
            .addr   (addr_a[g]),
            .wdata  (wdata_a[g]),
            .addr_ok(addr_ok),
            .data_ok(data_ok),
            .rdata  (rdata),
            .busy   (busy)
        );

        assign addr_ok_v[g] = addr_ok;
        assign busy_v[g]    = busy;

        // Model: each accepted request retires at max(accept, previous retire) + 1 + WAIT
        always @(posedge clk) begin
            int          sz;
            pend_t       p;
            logic [31:0] w;
            int          base;
            e++;
            if (rst_v[g]) begin
                pq.delete();
                exp_dok  = 1'b0;
                exp_rd   = 32'h0;
                last_ret = -100;
                started  = 1'b1;
            end else if (started) begin
                sz = pq.size();
                exp_dok = 1'b0;
                if (sz > 0 && pq[0].ret == e) begin
                    p = pq.pop_front();
                    exp_dok = 1'b1;
                    if (p.wr) begin
                        w = mm.exists(p.idx) ? mm[p.idx] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (p.wstrb[b]) w[8*b +: 8] = p.wdata[8*b +: 8];
                        if (p.wstrb != 4'h0) mm[p.idx] = w;
                        exp_rd = 32'h0;
                    end else begin
                        exp_rd = mm.exists(p.idx) ? mm[p.idx] : 32'hx;
                    end
                end
                if (req_v[g] && sz < int'(QD)) begin
                    base    = (e > last_ret) ? e : last_ret;
                    p.wr    = wr_v[g];
                    p.idx   = (addr_a[g] >> 2) & 32'h3FF;
                    p.wdata = wdata_a[g];
                    p.wstrb = wstrb_a[g];
                    p.ret   = base + 1 + int'(WT);
                    last_ret = p.ret;
                    pq.push_back(p);
                    acc_t.push_back(e);
                end
            end
        end

        always @(posedge clk) begin
            #1;
            if (started) begin
                chk($sformatf("u%0d data_ok @%0d", g, e), 32'(data_ok), 32'(exp_dok));
                chk($sformatf("u%0d rdata @%0d", g, e), rdata, exp_rd);
                chk($sformatf("u%0d addr_ok @%0d", g, e), 32'(addr_ok),
                    32'(!rst_v[g] && pq.size() < int'(QD)));
                chk($sformatf("u%0d busy @%0d", g, e), 32'(busy), 32'(pq.size() > 0));
                if (data_ok === 1'b1) begin
                    resp_q.push_back(rdata);
                    resp_t.push_back(e);
                end
            end
        end
    end

    // present a request at the falling edge and hold it until addr_ok shows it will be taken
    task automatic issue(input int i, input bit w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req_v[i] = 1'b1;
        wr_v[i] = w;
        wstrb_a[i] = s;
        addr_a[i] = a;
        wdata_a[i] = d;
        #1;
        while (!addr_ok_v[i] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("u%0d accept within bound", i), 32'(addr_ok_v[i]), 32'd1);
    endtask

    task automatic idle(input int i);
        @(negedge clk);
        req_v[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        @(negedge clk);
        while (busy_v[i] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d drains", i), 32'(busy_v[i]), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int a0;
        int n;
        rst_v = 3'b111;
        req_v = 3'b000;
        wr_v  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            wstrb_a[i] = 4'h0;
            addr_a[i]  = 32'h0;
            wdata_a[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("reset addr_ok", 32'(addr_ok_v), 32'h0);
        chk("reset busy", 32'(busy_v), 32'h0);
        chk("reset data_ok", 32'(g_inst[0].data_ok), 32'h0);
        chk("reset rdata", g_inst[1].rdata, 32'h0);
        rst_v = 3'b000;
        #1;
        chk("addr_ok after reset", 32'(addr_ok_v), 32'h7);

        // WAIT=0: back-to-back traffic
        issue(0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        issue(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        issue(0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
        issue(0, 1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD);
        issue(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        issue(0, 1'b1, 4'hF, 32'h1234_0008, 32'h5A5A_1234);
        issue(0, 1'b0, 4'hF, 32'h0000_1008, 32'h0);
        issue(0, 1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D);
        issue(0, 1'b1, 4'h0, 32'h0000_0030, 32'h1234_5678);
        issue(0, 1'b0, 4'hF, 32'h0000_0030, 32'h0);
        idle(0);
        wait_idle(0);
        chk("u0 response count", 32'(g_inst[0].resp_q.size()), 32'd10);
        if (g_inst[0].resp_q.size() == 10) begin
            chk("u0 write resp rdata", g_inst[0].resp_q[0], 32'h0);
            chk("u0 read deadbeef", g_inst[0].resp_q[1], 32'hDEAD_BEEF);
            chk("u0 byte merge", g_inst[0].resp_q[4], 32'h11BB_33DD);
            chk("u0 alias read", g_inst[0].resp_q[6], 32'h5A5A_1234);
            chk("u0 wstrb0 resp", g_inst[0].resp_q[8], 32'h0);
            chk("u0 wstrb0 keeps word", g_inst[0].resp_q[9], 32'hCAFE_F00D);
            chk("u0 first latency", 32'(g_inst[0].resp_t[0] - g_inst[0].acc_t[0]), 32'd1);
            chk("u0 consecutive pulses", 32'(g_inst[0].resp_t[1] - g_inst[0].resp_t[0]), 32'd1);
            chk("u0 throughput", 32'(g_inst[0].resp_t[9] - g_inst[0].resp_t[0]), 32'd9);
        end

        // WAIT=3, QDEPTH=2: three reads with req held every cycle
        issue(1, 1'b1, 4'hF, 32'h0000_0040, 32'hA0A0_A0A0);
        issue(1, 1'b1, 4'hF, 32'h0000_0044, 32'hB1B1_B1B1);
        issue(1, 1'b1, 4'hF, 32'h0000_0048, 32'hC2C2_C2C2);
        idle(1);
        wait_idle(1);
        n0 = g_inst[1].resp_q.size();
        a0 = g_inst[1].acc_t.size();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_v[1]  = 1'b1;
            wr_v[1]   = 1'b0;
            addr_a[1] = 32'h40 + 32'(4 * k);
            #1;
            ao_hist.push_back(addr_ok_v[1]);
            n = 0;
            while (!addr_ok_v[1] && n < 40) begin
                @(negedge clk);
                #1;
                ao_hist.push_back(addr_ok_v[1]);
                n++;
            end
        end
        idle(1);
        wait_idle(1);
        chk("u1 addr_ok samples", 32'(ao_hist.size()), 32'd6);
        if (ao_hist.size() >= 3) begin
            chk("u1 addr_ok[0]", 32'(ao_hist[0]), 32'd1);
            chk("u1 addr_ok[1]", 32'(ao_hist[1]), 32'd1);
            chk("u1 addr_ok[2]", 32'(ao_hist[2]), 32'd0);
        end
        chk("u1 read responses", 32'(g_inst[1].resp_q.size() - n0), 32'd3);
        if (g_inst[1].resp_q.size() == n0 + 3) begin
            chk("u1 order 0", g_inst[1].resp_q[n0], 32'hA0A0_A0A0);
            chk("u1 order 1", g_inst[1].resp_q[n0+1], 32'hB1B1_B1B1);
            chk("u1 order 2", g_inst[1].resp_q[n0+2], 32'hC2C2_C2C2);
            chk("u1 first latency", 32'(g_inst[1].resp_t[n0] - g_inst[1].acc_t[a0]), 32'd4);
            chk("u1 spacing 1", 32'(g_inst[1].resp_t[n0+1] - g_inst[1].resp_t[n0]), 32'd4);
            chk("u1 spacing 2", 32'(g_inst[1].resp_t[n0+2] - g_inst[1].resp_t[n0+1]), 32'd4);
        end

        // WAIT=5: reset with two writes queued
        issue(2, 1'b1, 4'hF, 32'h0000_0050, 32'h0101_0101);
        issue(2, 1'b1, 4'hF, 32'h0000_0054, 32'h0202_0202);
        idle(2);
        wait_idle(2);
        n0 = g_inst[2].resp_q.size();
        issue(2, 1'b1, 4'hF, 32'h0000_0050, 32'hFFFF_FFFF);
        issue(2, 1'b1, 4'hF, 32'h0000_0054, 32'hEEEE_EEEE);
        @(negedge clk);
        req_v[2] = 1'b0;
        rst_v[2] = 1'b1;
        #1;
        chk("u2 addr_ok in reset", 32'(addr_ok_v[2]), 32'd0);
        @(negedge clk);
        rst_v[2] = 1'b0;
        #1;
        chk("u2 addr_ok after reset", 32'(addr_ok_v[2]), 32'd1);
        chk("u2 queue flushed", 32'(busy_v[2]), 32'd0);
        repeat (12) @(negedge clk);
        chk("u2 no data_ok after reset", 32'(g_inst[2].resp_q.size() - n0), 32'd0);
        issue(2, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
        issue(2, 1'b0, 4'hF, 32'h0000_0054, 32'h0);
        idle(2);
        wait_idle(2);
        chk("u2 post-reset reads", 32'(g_inst[2].resp_q.size() - n0), 32'd2);
        if (g_inst[2].resp_q.size() == n0 + 2) begin
            chk("u2 word 0x50 kept", g_inst[2].resp_q[n0], 32'h0101_0101);
            chk("u2 word 0x54 kept", g_inst[2].resp_q[n0+1], 32'h0202_0202);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
